// File: rtl/serial_addsub_digit.sv
// serial_addsub_digit: digit-serial adder/subtractor, LSD first, framed by vld/last.
// Ports: clk, rst (async, active-high); vld/a/b/sub/last carry one operand digit per
// beat; sum_vld/sum/sum_last form the registered result stream; carry_out, ovf and
// err are final-beat flags, 0 on every other cycle.
module serial_addsub_digit #(
  parameter int DIGIT_W   = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               sum_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               sum_last,
  output logic               carry_out,
  output logic               ovf,
  output logic               err
);
  localparam int CW = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic carry_q, carry_d, mode_q, mode_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic sum_vld_q, sum_vld_d, sum_last_q, sum_last_d;
  logic carry_out_q, carry_out_d, ovf_q, ovf_d, err_q, err_d;
  logic [DIGIT_W-1:0] sum_q, sum_d, b_eff, s;
  logic idle, m, cin, term, c_msb, c_in_msb;
  always_comb begin
    idle = state_q == IDLE;
    m = idle ? sub : mode_q;
    b_eff = m ? ~b : b;
    // subtraction injects its +1 on the first digit only; later digits chain the carry
    cin = idle ? m : carry_q;
    {c_msb, s} = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    // carry into the top bit recovered from the top-bit sum
    c_in_msb = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ s[DIGIT_W-1];
    term = last | (beat_cnt_q == CW'(MAX_BEATS - 1));
    sum_vld_d = vld;
    sum_d = vld ? s : sum_q;
    sum_last_d = vld & term;
    carry_out_d = vld & term & c_msb;
    ovf_d = vld & term & (c_msb ^ c_in_msb);
    err_d = vld & term & ~last;
    state_d = vld ? (term ? IDLE : BUSY) : state_q;
    mode_d = vld ? m : mode_q;
    carry_d = vld ? ~term & c_msb : carry_q;
    beat_cnt_d = vld ? (term ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      mode_q <= 1'b0;
      beat_cnt_q <= '0;
      sum_vld_q <= 1'b0;
      sum_q <= '0;
      sum_last_q <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      mode_q <= mode_d;
      beat_cnt_q <= beat_cnt_d;
      sum_vld_q <= sum_vld_d;
      sum_q <= sum_d;
      sum_last_q <= sum_last_d;
      carry_out_q <= carry_out_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign sum_vld = sum_vld_q;
  assign sum = sum_q;
  assign sum_last = sum_last_q;
  assign carry_out = carry_out_q;
  assign ovf = ovf_q;
  assign err = err_q;
endmodule

// File: tb/tb_serial_addsub_digit.sv
// tb_serial_addsub_digit: vector table, hand sequences and random packets vs an arithmetic model.
module tb_serial_addsub_digit;
  localparam int W = 4;
  localparam int MAXB = 8;
  logic clk = 0, rst = 1, vld = 0, sub = 0, last = 0;
  logic [W-1:0] a = 0, b = 0;
  logic sum_vld, sum_last, carry_out, ovf, err;
  logic [W-1:0] sum;
  int pass_cnt = 0, tot_cnt = 0;
  serial_addsub_digit #(.DIGIT_W(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
    .sum_vld(sum_vld), .sum(sum), .sum_last(sum_last),
    .carry_out(carry_out), .ovf(ovf), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit v; logic [W-1:0] a, b; bit s, l;
    bit e_vld; logic [W-1:0] e_sum; bit e_last, e_co, e_ovf, e_err;
  } vec_t;
  vec_t tbl[$];
  bit in_pkt, m_mode;
  int k;
  longint ma, mb;
  bit x_vld, x_last, x_co, x_ovf, x_err;
  logic [W-1:0] x_sum = 0;
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
  endtask
  task automatic chk_all(input string tag, input bit ev, input logic [W-1:0] es,
                         input bit el, input bit ec, input bit eo, input bit ee);
    chk({tag, ".sum_vld"}, W'(sum_vld), W'(ev));
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".sum_last"}, W'(sum_last), W'(el));
    chk({tag, ".carry_out"}, W'(carry_out), W'(ec));
    chk({tag, ".ovf"}, W'(ovf), W'(eo));
    chk({tag, ".err"}, W'(err), W'(ee));
  endtask
  // whole-packet arithmetic: digit i of the result depends only on digits 0..i of the operands
  task automatic model(input bit v, input logic [W-1:0] ai, input logic [W-1:0] bi, input bit si, input bit li);
    longint r, half, sa, sb, res;
    int n;
    x_vld = v; x_last = 0; x_co = 0; x_ovf = 0; x_err = 0;
    if (v) begin
      if (!in_pkt) begin m_mode = si; ma = 0; mb = 0; k = 0; end
      ma = ma | (longint'(ai) << (k * W));
      mb = mb | (longint'(bi) << (k * W));
      k++;
      n = k * W;
      r = m_mode ? ma + (64'sd1 << n) - mb : ma + mb;
      x_sum = W'(r >> ((k - 1) * W));
      if (li || k == MAXB) begin
        half = 64'sd1 << (n - 1);
        sa = ma >= half ? ma - 2 * half : ma;
        sb = mb >= half ? mb - 2 * half : mb;
        res = m_mode ? sa - sb : sa + sb;
        x_last = 1;
        x_co = r[n];
        x_ovf = res < -half || res >= half;
        x_err = !li;
        in_pkt = 0;
      end else in_pkt = 1;
    end
  endtask
  task automatic apply(input bit v, input logic [W-1:0] ai, input logic [W-1:0] bi, input bit si, input bit li);
    @(negedge clk);
    vld = v; a = ai; b = bi; sub = si; last = li;
    @(posedge clk);
    #1;
    model(v, ai, bi, si, li);
  endtask
  initial begin
    tbl.push_back('{1, 4'hA, 4'hC, 0, 0, 1, 4'h6, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h3, 4'h2, 0, 1, 1, 4'h6, 1, 0, 0, 0});
    tbl.push_back('{1, 4'h5, 4'h7, 1, 0, 1, 4'hE, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h0, 4'h0, 0, 1, 1, 4'hF, 1, 0, 0, 0});
    tbl.push_back('{1, 4'hF, 4'h1, 0, 0, 1, 4'h0, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h7, 4'h0, 0, 1, 1, 4'h8, 1, 0, 1, 0});
    tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 1, 4'h0, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h8, 4'h8, 0, 1, 1, 4'h0, 1, 1, 1, 0});
    tbl.push_back('{1, 4'hA, 4'hC, 0, 0, 1, 4'h6, 0, 0, 0, 0});
    tbl.push_back('{0, 4'h0, 4'h0, 0, 1, 0, 4'h6, 0, 0, 0, 0});
    tbl.push_back('{0, 4'h0, 4'h0, 0, 1, 0, 4'h6, 0, 0, 0, 0});
    tbl.push_back('{0, 4'h0, 4'h0, 0, 0, 0, 4'h6, 0, 0, 0, 0});
    tbl.push_back('{1, 4'h3, 4'h2, 0, 1, 1, 4'h6, 1, 0, 0, 0});
    for (int i = 0; i < MAXB; i++)
      tbl.push_back('{1, 4'hF, 4'h0, 0, 0, 1, 4'hF, i == MAXB - 1, 0, 0, i == MAXB - 1});
    tbl.push_back('{1, 4'h1, 4'h1, 0, 1, 1, 4'h2, 1, 0, 0, 0});
    for (int i = 0; i < MAXB; i++)
      tbl.push_back('{1, 4'hF, 4'h0, 0, i == MAXB - 1, 1, 4'hF, i == MAXB - 1, 0, 0, 0});
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].l);
      chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_sum, tbl[i].e_last,
              tbl[i].e_co, tbl[i].e_ovf, tbl[i].e_err);
    end
    apply(1, 4'hF, 4'h2, 0, 0);
    chk_all("pre_rst", 1, 4'h1, 0, 0, 0, 0);
    #2;
    vld = 0;
    rst = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    in_pkt = 0;
    x_sum = 0;
    @(negedge clk);
    rst = 0;
    apply(1, 4'h0, 4'h0, 0, 1);
    chk_all("post_rst", 1, 4'h0, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(3, 0) != 0, W'($urandom), W'($urandom), $urandom_range(1, 0) == 1,
            $urandom_range(9, 0) < 2);
      chk_all($sformatf("rnd%0d", i), x_vld, x_sum, x_last, x_co, x_ovf, x_err);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
Parametrised serial adder/subtractor. It processes one DIGIT_W-bit digit of each operand per valid beat, least-significant digit first, with packet framing by vld/last. It is the next generation of the team's 1-bit serial adder: configurable digit width, per-packet add/sub mode, registered output stream, final carry/overflow flags and a maximum-length guard. It sits between serial operand sources and a serial result sink.

Parameters:
DIGIT_W, 4, bits per beat for each operand and the result (>=1).
MAX_BEATS, 8, maximum beats per packet before forced termination (>=1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
vld  input  1  a, b, sub and last are valid this cycle.
a  input  DIGIT_W  operand A digit, LSD first.
b  input  DIGIT_W  operand B digit, LSD first.
sub  input  1  mode, sampled only on the first beat of a packet: 0 = A+B, 1 = A-B.
last  input  1  current beat is the MSD of the packet; ignored when vld=0.
sum_vld  output  1  sum digit valid (registered copy of vld).
sum  output  DIGIT_W  result digit.
sum_last  output  1  sum digit is the final digit of the packet.
carry_out  output  1  carry out of the MSD (sub: 1 = no borrow); valid when sum_vld&sum_last, else 0.
ovf  output  1  two's-complement signed overflow of the whole packet; valid when sum_vld&sum_last, else 0.
err  output  1  packet was terminated by MAX_BEATS without last; valid when sum_vld&sum_last, else 0.

Behaviour:
- Reset (async, any time, including mid-packet): state=IDLE, carry=0, beat_cnt=0, mode=0, and all outputs 0. The next vld beat after reset release is a first beat.
- States: IDLE (next beat is first) and BUSY (mid-packet).
- Effective mode m = sub when in IDLE, else latched mode. On the first beat, latch mode<=sub. sub is ignored in BUSY.
- Per vld beat: b_eff = m ? ~b : b; cin = IDLE ? m : carry. {c_msb, s} = a + b_eff + cin, computed at DIGIT_W+1 width. c_in_msb = carry into bit DIGIT_W-1.
- term = last | (beat_cnt == MAX_BEATS-1).
- Registered outputs, latency 1 cycle. sum_vld<=vld. On vld: sum<=s; sum_last<=term; carry_out<=term&c_msb; ovf<=term&(c_msb^c_in_msb); err<=term&~last.
- On a non-vld cycle: sum_vld=0, sum_last/carry_out/ovf/err=0, sum holds its previous value. carry, mode, state and beat_cnt hold, so bubbles anywhere inside a packet are transparent.
- State update on vld: if term, then state<=IDLE, carry<=0, beat_cnt<=0. Otherwise state<=BUSY, carry<=c_msb, beat_cnt++.
- Single-beat packet (vld&last in IDLE): full result on that beat; mode uses sub directly.
- last with vld=0 has no effect.
- Forced termination: the MAX_BEATS-th beat without last becomes the final beat with err=1. The following vld beat starts a new packet, and last on it ends that new packet.
- last on exactly the MAX_BEATS-th beat: normal end, err=0.

Test Plan:
- DIGIT_W=4, add: beats (a,b)=(A,C),(3,2,last) -> sum 6 then 6 (0x66), sum_last on beat 2, carry_out=0, ovf=0, err=0. Carry 1 propagates between beats.
- Sub: first beat sub=1, (5,7), then (0,0,last) with sub=0 (ignored) -> sum E,F (0xFE = -2), carry_out=0 (borrow), ovf=0.
- Signed overflow: add (F,1),(7,0,last) -> sum 0,8 (0x80), ovf=1, carry_out=0. Also (0,0),(8,8,last) -> sum 0,0, ovf=1, carry_out=1.
- Bubbles: add 0x3A+0x2C with 3 idle cycles between beats and last pulsed during idle cycles -> identical result to test 1; idle last ignored; sum_vld low during gaps.
- MAX_BEATS=8: 8 beats (F,0) without last -> 8th output has sum_last=1, err=1. The next beat (1,1,last) is a fresh packet -> sum 2, err=0, carry_out=0.
- Async reset asserted mid-packet after a beat leaving carry=1, without a clock edge -> outputs 0 immediately. After release, (0,0,last) -> sum 0, carry_out=0 (carry cleared, mode add).
